// File: rtl/shift_unit_seq.sv
// Sequential barrel shifter: one log-stage per cycle (stage k shifts by 2^k when cnt[k] is set),
// with a valid/ready request port and a valid/ready result port.
module shift_unit_seq #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CW    = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [CW-1:0]    in_cnt,
  input  logic [1:0]       in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_zero
);

  localparam int unsigned KW = (CW > 1) ? $clog2(CW) : 1;

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;
  typedef enum logic [1:0] {OpRol = 2'b00, OpSll = 2'b01, OpRor = 2'b10, OpSra = 2'b11} op_e;

  state_e           state_q, state_d;
  logic [KW-1:0]    k_q, k_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  op_e              op_q, op_d;

  logic [CW:0]      sh_amt;
  logic [CW:0]      rot_amt;
  logic [WIDTH-1:0] stage_res;

  // Stage k moves data by 2^k; rotates recombine with the complementary shift.
  always_comb begin
    sh_amt    = (CW+1)'(1) << k_q;
    rot_amt   = (CW+1)'(WIDTH) - sh_amt;
    stage_res = data_q;
    unique case (op_q)
      OpRol: stage_res = (data_q << sh_amt) | (data_q >> rot_amt);
      OpSll: stage_res = data_q << sh_amt;
      OpRor: stage_res = (data_q >> sh_amt) | (data_q << rot_amt);
      OpSra: stage_res = $signed(data_q) >>> sh_amt;
    endcase
  end

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          data_d  = in_data;
          cnt_d   = in_cnt;
          op_d    = op_e'(in_op);
          k_d     = '0;
          state_d = StShift;
        end
      end
      StShift: begin
        if (cnt_q[k_q]) data_d = stage_res;
        k_d = k_q + 1'b1;
        if (k_q == KW'(CW - 1)) state_d = StDone;
      end
      StDone: begin
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      k_q     <= '0;
      data_q  <= '0;
      cnt_q   <= '0;
      op_q    <= OpRol;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign out_data  = data_q;
  assign out_zero  = ~|data_q;

endmodule

// File: tb/tb_shift_unit_seq.sv
// Directed bench for shift_unit_seq (WIDTH=16, CW=4) with hand-computed expected results.
module tb_shift_unit_seq;

  localparam int unsigned WIDTH = 16;
  localparam int unsigned CW    = 4;

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic [CW-1:0]    in_cnt;
  logic [1:0]       in_op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_zero;

  int n_checks = 0;
  int n_fail   = 0;

  shift_unit_seq #(.WIDTH(WIDTH), .CW(CW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_cnt    (in_cnt),
    .in_op     (in_op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_zero  (out_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Present a request and take the accept edge; returns 1ns after that edge.
  task automatic issue(input logic [1:0] op, input logic [15:0] data, input logic [3:0] cnt);
    in_valid = 1'b1;
    in_op    = op;
    in_data  = data;
    in_cnt   = cnt;
    check("in_ready_before_accept", {31'b0, in_ready}, 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_data  = 16'hDEAD;
    in_cnt   = 4'hF;
    in_op    = 2'b11;
  endtask

  // Count edges until out_valid, bounded.
  task automatic wait_done(output int lat);
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic handoff(input string tag);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check({tag, "_idle_ready"}, {31'b0, in_ready}, 32'd1);
    check({tag, "_idle_valid"}, {31'b0, out_valid}, 32'd0);
  endtask

  task automatic run_op(input string tag, input logic [1:0] op, input logic [15:0] data,
                        input logic [3:0] cnt, input logic [15:0] exp);
    int lat;
    issue(op, data, cnt);
    wait_done(lat);
    check({tag, "_latency"}, lat, 32'd4);
    check({tag, "_data"}, {16'b0, out_data}, {16'b0, exp});
    check({tag, "_zero"}, {31'b0, out_zero}, {31'b0, (exp == 16'h0)});
    handoff(tag);
  endtask

  initial begin
    int lat;
    logic [15:0] held;
    int seen_valid;

    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_cnt    = '0;
    in_op     = '0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("rst_in_ready", {31'b0, in_ready}, 32'd1);
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_out_data", {16'b0, out_data}, 32'h0);
    check("rst_out_zero", {31'b0, out_zero}, 32'd1);
    @(posedge clk);
    #1;

    // 00 ROL, 01 SLL, 10 ROR, 11 SRA
    run_op("ror_1234_4",  2'b10, 16'h1234, 4'd4,  16'h4123);
    run_op("rol_8001_1",  2'b00, 16'h8001, 4'd1,  16'h0003);
    run_op("sll_00ff_8",  2'b01, 16'h00FF, 4'd8,  16'hFF00);
    run_op("sll_8000_1",  2'b01, 16'h8000, 4'd1,  16'h0000);
    run_op("sra_8000_15", 2'b11, 16'h8000, 4'd15, 16'hFFFF);
    run_op("sra_4000_14", 2'b11, 16'h4000, 4'd14, 16'h0001);
    run_op("rol_cnt0",    2'b00, 16'hA5C3, 4'd0,  16'hA5C3);
    run_op("sll_cnt0",    2'b01, 16'hA5C3, 4'd0,  16'hA5C3);
    run_op("ror_cnt0",    2'b10, 16'hA5C3, 4'd0,  16'hA5C3);
    run_op("sra_cnt0",    2'b11, 16'hA5C3, 4'd0,  16'hA5C3);
    run_op("ror_8001_15", 2'b10, 16'h8001, 4'd15, 16'h0003);
    run_op("rol_1234_12", 2'b00, 16'h1234, 4'd12, 16'h4123);

    // Backpressure: hold DONE three cycles while a new request waits.
    issue(2'b00, 16'h0F0F, 4'd4);
    wait_done(lat);
    check("bp_latency", lat, 32'd4);
    held      = out_data;
    check("bp_data", {16'b0, held}, 32'h0000F0F0);
    in_valid = 1'b1;
    in_op    = 2'b01;
    in_data  = 16'h0001;
    in_cnt   = 4'd3;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check("bp_hold_data", {16'b0, out_data}, {16'b0, held});
      check("bp_hold_valid", {31'b0, out_valid}, 32'd1);
      check("bp_hold_ready", {31'b0, in_ready}, 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check("bp_handoff_ready", {31'b0, in_ready}, 32'd1);
    check("bp_handoff_valid", {31'b0, out_valid}, 32'd0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("bp_accept_next", {31'b0, in_ready}, 32'd0);
    wait_done(lat);
    check("bp_next_latency", lat, 32'd4);
    check("bp_next_data", {16'b0, out_data}, 32'h00000008);
    handoff("bp_next");

    // Reset in the middle of a ROR, after stages 0 and 1 have been applied.
    issue(2'b10, 16'h1234, 4'd15);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("abort_valid", {31'b0, out_valid}, 32'd0);
    check("abort_ready", {31'b0, in_ready}, 32'd1);
    check("abort_data", {16'b0, out_data}, 32'h0);
    check("abort_zero", {31'b0, out_zero}, 32'd1);
    #1;
    rst = 1'b0;
    seen_valid = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      if (out_valid) seen_valid++;
    end
    check("abort_no_valid", seen_valid, 32'd0);
    run_op("post_abort_sra", 2'b11, 16'hF000, 4'd4, 16'hFF00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/shift_unit_seq.md
SHIFT_UNIT_SEQ -- requirements
Module: shift_unit_seq

Interface
REQ-001 The module SHALL have parameter WIDTH, default 16, the operand width in bits; it SHALL be a power of two, at least 2.
REQ-002 The module SHALL have parameter CW, default 4, the shift-count width; it SHALL equal log2(WIDTH).
REQ-003 The module SHALL have port clk, input, 1 bit: the single clock, rising-edge active.
REQ-004 The module SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 The module SHALL have port in_valid, input, 1 bit: the request is valid.
REQ-006 The module SHALL have port in_ready, output, 1 bit: the unit can accept a request.
REQ-007 The module SHALL have port in_data, input, WIDTH bits: the operand.
REQ-008 The module SHALL have port in_cnt, input, CW bits: the shift amount, 0..WIDTH-1.
REQ-009 The module SHALL have port in_op, input, 2 bits: the operation, with 00 ROL, 01 SLL, 10 ROR, 11 SRA.
REQ-010 The module SHALL have port out_valid, output, 1 bit: the result is valid.
REQ-011 The module SHALL have port out_ready, input, 1 bit: the consumer accepts the result.
REQ-012 The module SHALL have port out_data, output, WIDTH bits: the result.
REQ-013 The module SHALL have port out_zero, output, 1 bit: out_data equals 0.

Function
REQ-014 The FSM SHALL have exactly three states: IDLE, SHIFT and DONE.
REQ-015 The unit SHALL assert in_ready exactly when in IDLE.
REQ-016 The unit SHALL assert out_valid exactly when in DONE.
REQ-017 On a rising edge in IDLE with in_valid=1 (accept), the unit SHALL:
- register in_data, in_cnt and in_op internally;
- clear the stage index k to 0;
- go to SHIFT.
REQ-018 In IDLE with in_valid=0, the unit SHALL stay in IDLE and hold all registers.
REQ-019 On each SHIFT edge, the unit SHALL apply stage k to the data register: shift or rotate by 2^k when the registered cnt[k]=1, pass through unchanged otherwise; k then increments.
REQ-020 The stage operations SHALL be:
- ROL: rotate left, bits leaving the MSB enter the LSB;
- ROR: rotate right, bits leaving the LSB enter the MSB;
- SLL: shift left with zero fill;
- SRA: shift right filling with the current MSB.
REQ-021 On the SHIFT edge that applies stage CW-1, the unit SHALL go to DONE.
REQ-022 Latency SHALL be exactly CW edges from the accept edge to the edge that sets out_valid, for every in_cnt value including 0.
REQ-023 In DONE, out_data and out_zero SHALL be held stable until handoff.
REQ-024 On an edge with out_valid=1 and out_ready=1 (handoff), the unit SHALL go to IDLE.
REQ-025 A request SHALL NOT be accepted on the handoff edge; the next accept occurs no earlier than the following edge.
REQ-026 The unit SHALL ignore changes to in_data, in_cnt, in_op and in_valid while in SHIFT or DONE.
REQ-027 out_ready SHALL be ignored outside DONE.
REQ-028 out_data SHALL present the data register in all states; it is meaningful only while out_valid=1.
REQ-029 out_zero SHALL be combinational from out_data.
REQ-030 Throughput SHALL be at most one operation per CW+2 cycles.

Reset
REQ-031 While rst=1, the unit SHALL be held in IDLE with k=0, data register 0 and cnt/op registers 0, independent of clk.
REQ-032 Immediately after rst deasserts, the outputs SHALL be: in_ready=1, out_valid=0, out_data=0, out_zero=1.
REQ-033 A reset asserted during SHIFT or DONE SHALL abort the operation; no out_valid pulse for the aborted request SHALL appear after reset.

Verification (WIDTH=16, CW=4)
REQ-034 The bench SHALL cover: ROR 0x1234 cnt 4 -> out_data 0x4123, out_valid rises 4 edges after accept, out_zero=0.
REQ-035 The bench SHALL cover:
- ROL 0x8001 cnt 1 -> 0x0003;
- SLL 0x00FF cnt 8 -> 0xFF00;
- SLL 0x8000 cnt 1 -> 0x0000 with out_zero=1.
REQ-036 The bench SHALL cover:
- SRA 0x8000 cnt 15 -> 0xFFFF;
- SRA 0x4000 cnt 14 -> 0x0001.
REQ-037 The bench SHALL cover: any op with cnt 0 on 0xA5C3 -> 0xA5C3, with latency still 4 edges.
REQ-038 The bench SHALL cover backpressure: out_ready=0 for 3 cycles in DONE -> out_data stable, in_ready=0, and a new in_valid/in_data is ignored; then out_ready=1 -> IDLE, and the new request is accepted on the next edge.
REQ-039 The bench SHALL cover: rst pulsed at k=2 of a ROR -> out_valid=0, in_ready=1, out_data=0 immediately; a fresh request afterwards completes correctly.
